// File: rtl/i2s_adc_rx_pkg.sv
// i2s_adc_rx_pkg: shared types and constants for the I2S ADC receiver
package i2s_adc_rx_pkg;
  localparam int DIV_W = 8;
  localparam int PAIR_DW = 16;
  typedef struct packed {
    logic [PAIR_DW-1:0] left;
    logic [PAIR_DW-1:0] right;
  } i2s_pair_t;
  typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_ch_e;
endpackage

// File: rtl/i2s_adc_rx_fifo.sv
// i2s_adc_rx_fifo: first-word-fall-through FIFO of stereo pairs with flush
module i2s_adc_rx_fifo import i2s_adc_rx_pkg::*; #(
  parameter type T = i2s_pair_t,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // head reads as zero when empty so outputs match reset values after a flush
  assign dout = empty ? T'('0) : mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end
endmodule

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S master receiver generating sclk/lrck and buffering stereo pairs
module i2s_adc_rx import i2s_adc_rx_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [DIV_W-1:0]            div_i,
  input  logic                        clr_i,
  output logic                        i2s_sclk_o,
  output logic                        i2s_lrck_o,
  input  logic                        i2s_adcdat_i,
  output logic                        data_valid_o,
  input  logic                        data_ready_i,
  output logic [DATA_WIDTH-1:0]       data_left_o,
  output logic [DATA_WIDTH-1:0]       data_right_o,
  output logic                        overrun_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;
  localparam int BW = $clog2(DATA_WIDTH);
  logic [DIV_W-1:0] div_cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_WIDTH-2:0] shift;
  logic [DATA_WIDTH-1:0] left_hold, word;
  logic left_ok, tick, rise, fall, last_bit, push, pop, full, empty;
  i2s_ch_e ch;
  pair_t pair_in, head;
  assign tick = div_cnt == div_i;
  assign rise = tick && !i2s_sclk_o;
  assign fall = tick && i2s_sclk_o;
  assign last_bit = bit_idx == BW'(DATA_WIDTH - 1);
  assign word = {shift, i2s_adcdat_i};
  // one-bit I2S delay: a word completes at the first rise of the following slot
  assign push = en_i && rise && bit_idx == '0 && ch == CH_LEFT && left_ok;
  assign pop = data_valid_o && data_ready_i;
  assign pair_in = {left_hold, word};
  assign i2s_lrck_o = ch;
  assign data_valid_o = !empty;
  assign data_left_o = head.left;
  assign data_right_o = head.right;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      i2s_sclk_o <= 1'b0;
      ch <= CH_LEFT;
      bit_idx <= '0;
      shift <= '0;
      left_hold <= '0;
      left_ok <= 1'b0;
    end else if (!en_i) begin
      div_cnt <= '0;
      i2s_sclk_o <= 1'b0;
      ch <= CH_LEFT;
      bit_idx <= '0;
      shift <= '0;
      left_hold <= '0;
      left_ok <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) i2s_sclk_o <= !i2s_sclk_o;
      if (rise) shift <= word[DATA_WIDTH-2:0];
      if (rise && bit_idx == '0 && ch == CH_RIGHT) begin
        left_hold <= word;
        left_ok <= 1'b1;
      end
      if (fall) begin
        bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
        if (last_bit) ch <= (ch == CH_LEFT) ? CH_RIGHT : CH_LEFT;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overrun_o <= 1'b0;
    else overrun_o <= (push && full && !pop) || (overrun_o && !clr_i);
  end
  i2s_adc_rx_fifo #(.T(pair_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .flush(clr_i),
    .push(push),
    .pop(pop),
    .din(pair_in),
    .dout(head),
    .full(full),
    .empty(empty),
    .cnt(fifo_cnt_o)
  );
endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: I2S slave transmitter model driving the receiver, with a pop scoreboard
module tb_i2s_adc_rx;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, en = 0, clr = 0, adcdat = 0, ready = 0;
  logic [7:0] div = 8'd1;
  logic sclk, lrck, valid, ovr;
  logic [15:0] left, right;
  logic [3:0] cnt;
  int checks = 0, errors = 0, pushes = 0, pops = 0, fidx = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pop = '0, first_pop = '0;
  bit pend = 0;

  always #5 clk = ~clk;

  i2s_adc_rx dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .div_i(div), .clr_i(clr),
    .i2s_sclk_o(sclk), .i2s_lrck_o(lrck), .i2s_adcdat_i(adcdat),
    .data_valid_o(valid), .data_ready_i(ready),
    .data_left_o(left), .data_right_o(right),
    .overrun_o(ovr), .fifo_cnt_o(cnt)
  );

  function automatic logic [31:0] pair_of(input int n);
    logic [15:0] k;
    k = n[15:0];
    return (n < 3) ? 32'hA5C3_3C5A : {16'h8001 + k * 16'h0302, 16'h4002 ^ (k << 3)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pushes(input int n, input string nm);
    int t0 = pushes;
    int t = 0;
    while (pushes < t0 + n && t < 3000) begin step(); t++; end
    if (pushes < t0 + n) tmo(nm);
  endtask

  task automatic wait_pops(input int n, input string nm);
    int t0 = pops;
    int t = 0;
    while (pops < t0 + n && t < 600) begin step(); t++; end
    if (pops < t0 + n) tmo(nm);
  endtask

  task automatic wait_qempty(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin step(); t++; end
    if (exp_q.size() != 0) tmo(nm);
  endtask

  // Slave transmitter: data changes after sclk falls, MSB one bit after each lrck edge
  always @(posedge clk) begin
    static int bc = 0;
    static bit ps = 0, pl = 0, idle = 1;
    static logic [31:0] p = '0, pend_pair = '0;
    #1;
    if (rst || !en) begin
      if (!idle) fidx++;
      idle = 1; bc = 0; ps = 0; pl = 0; pend = 0;
    end else begin
      idle = 0;
      if (!ps && sclk && pend) begin
        pend = 0;
        pushes++;
        if (exp_q.size() < DEPTH) exp_q.push_back(pend_pair);
      end
      if (ps && !sclk) begin
        p = pair_of(fidx);
        if (lrck != pl) begin
          bc = 0;
          if (pl) begin
            adcdat = p[0];
            pend_pair = p;
            pend = 1;
            fidx++;
          end else adcdat = p[16];
        end else begin
          bc++;
          adcdat = lrck ? p[16 - bc] : p[32 - bc];
        end
        pl = lrck;
      end
      ps = sclk;
    end
  end

  always @(negedge clk) begin
    logic [31:0] got;
    if (!rst && valid && ready) begin
      got = {left, right};
      if (pops == 0) first_pop = got;
      pops++;
      last_pop = got;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected got=%h exp=none", got);
      end else chk("pop_data", got, exp_q.pop_front());
    end
  end

  initial begin
    int rise1, rise2, tg1, tg2, idx, t;
    bit ps_s, pl_s, vseen;
    repeat (2) step();
    chk("rst_sclk", sclk, 0);
    chk("rst_lrck", lrck, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", {left, right}, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_cnt", cnt, 0);
    rst = 0;
    step();
    en = 1;
    rise1 = -1; rise2 = -1; tg1 = -1; tg2 = -1; ps_s = 0; pl_s = 0; vseen = 0;
    for (int c = 1; c <= 128; c++) begin
      step();
      if (sclk && !ps_s) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      if (lrck != pl_s) begin
        if (tg1 < 0) tg1 = c;
        else if (tg2 < 0) tg2 = c;
      end
      vseen |= valid;
      ps_s = sclk;
      pl_s = lrck;
    end
    chk("first_rise", rise1, 2);
    chk("sclk_period", rise2 - rise1, 4);
    chk("lrck_first", tg1, 64);
    chk("lrck_half", tg2 - tg1, 64);
    chk("valid_first_frame", vseen, 0);
    ready = 1;
    wait_pops(2, "first_pops");
    chk("first_pair", first_pop, 32'hA5C3_3C5A);
    ready = 0;
    wait_pushes(10, "ovr_pushes");
    chk("ovr_cnt", cnt, 8);
    chk("ovr_flag", ovr, 1);
    ready = 1;
    wait_qempty("drain1");
    step();
    en = 0;
    ready = 0;
    repeat (3) step();
    chk("ovr_kept_disabled", ovr, 1);
    chk("cnt_model", cnt, exp_q.size());
    clr = 1;
    exp_q.delete();
    step();
    clr = 0;
    chk("clr_ovr", ovr, 0);
    chk("clr_cnt", cnt, 0);
    en = 1;
    wait_pushes(8, "fill8");
    chk("fill_cnt", cnt, 8);
    chk("fill_ovr", ovr, 0);
    t = 0;
    while (!pend && t < 300) begin step(); t++; end
    if (!pend) tmo("pend_wait");
    step();
    ready = 1;
    step();
    ready = 0;
    chk("full_pushpop_cnt", cnt, 8);
    chk("full_pushpop_ovr", ovr, 0);
    ready = 1;
    wait_qempty("drain2");
    chk("drain2_cnt", cnt, exp_q.size());
    t = 0;
    while (!lrck && t < 300) begin step(); t++; end
    if (!lrck) tmo("lrck_wait");
    repeat (30) step();
    en = 0;
    step();
    chk("dis_sclk", sclk, 0);
    chk("dis_lrck", lrck, 0);
    repeat (150) step();
    chk("dis_cnt", cnt, 0);
    chk("dis_valid", valid, 0);
    en = 1;
    step();
    idx = fidx;
    t = pops;
    wait_pops(1, "reen_pop");
    if (pops > t) chk("reen_pair", last_pop, pair_of(idx));
    ready = 0;
    wait_pushes(2, "rst_fill");
    chk("rst_fill_cnt", cnt, 2);
    t = 0;
    while (!sclk && t < 10) begin step(); t++; end
    #1 rst = 1;
    #1;
    chk("arst_sclk", sclk, 0);
    chk("arst_lrck", lrck, 0);
    chk("arst_valid", valid, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_data", {left, right}, 0);
    exp_q.delete();
    step();
    rst = 0;
    step();
    idx = fidx;
    ready = 1;
    t = pops;
    wait_pops(1, "post_rst_pop");
    if (pops > t) chk("post_rst_pair", last_pop, pair_of(idx));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_adc_rx.md
# i2s_adc_rx

I2S master-mode receiver for the audio ADC/microphone input path. It generates the bit clock `i2s_sclk_o` and word select `i2s_lrck_o` from the system clock and deserialises `i2s_adcdat_i` into stereo sample pairs. Pairs are buffered in a small FIFO and presented to the APB/register wrapper as a valid/ready stream. It is the receiving end of the I2S microphone link that the SoC-level bench drives with its mic transmitter model.

## Interface
- `DATA_WIDTH`, 16: bits per channel slot; a frame is 2*DATA_WIDTH sclk cycles.
- `FIFO_DEPTH`, 8: stereo pairs buffered; power of two, ≥2.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `en_i`  in  1  receiver enable; low holds the link idle.
- `div_i`  in  8  sclk half-period minus one, in clk cycles; changed only while `en_i`=0.
- `clr_i`  in  1  one-cycle pulse; clears `overrun_o` and flushes the FIFO.
- `i2s_sclk_o`  out  1  bit clock.
- `i2s_lrck_o`  out  1  word select; 0 = left, 1 = right.
- `i2s_adcdat_i`  in  1  serial data; the device changes it on sclk falling edges.
- `data_valid_o`  out  1  FIFO non-empty.
- `data_ready_i`  in  1  consumer pops on `valid && ready`.
- `data_left_o`  out  DATA_WIDTH  head-of-FIFO left sample.
- `data_right_o`  out  DATA_WIDTH  head-of-FIFO right sample.
- `overrun_o`  out  1  sticky: a pair was dropped because the FIFO was full.
- `fifo_cnt_o`  out  $clog2(FIFO_DEPTH)+1  occupancy.

## Operation
- Reset values: sclk=0, lrck=0, valid=0, left/right=0, overrun=0, cnt=0; all counters and the shift register are 0; `left_ok`=0.
- Clock generation: `div_cnt` counts 0..div_i. At `div_cnt==div_i` it wraps and sclk toggles. Resulting sclk frequency = f_clk/(2*(div_i+1)).
- Rise event (sclk 0→1 that cycle):
  - `shift <= {shift[DATA_WIDTH-2:0], i2s_adcdat_i}`.
  - The value sampled is the one present at that clk edge.
- Fall event (sclk 1→0):
  - `bit_idx` increments mod DATA_WIDTH.
  - On wrap to 0, lrck toggles.
- Standard I2S one-bit delay: the MSB of a channel is sampled at the 2nd rise after the lrck edge. The LSB is sampled at the 1st rise of the following slot.
- Word completion at a rise with `bit_idx==0`, using the shift value including the bit just sampled:
  - lrck=1 → the word is left: latch into `left_hold` and set `left_ok`.
  - lrck=0 and `left_ok` → the word is right: push `{left_hold, word}` to the FIFO.
  - lrck=0 and !`left_ok` → discard.
- Startup: the first left slot after enable is partial. `left_ok` gates the push, so the first pushed pair is complete.
- `en_i`=0: sclk, lrck, div_cnt, bit_idx, shift and `left_ok` are forced to reset values. The FIFO and overrun flag are kept. On `en_i` 0→1 the frame starts in the left slot with bit_idx=0.
- FIFO push when full and no pop in the same cycle: the pair is dropped and `overrun_o` is set. Push and pop together when full: both are accepted and the count is unchanged.
- `clr_i`: the FIFO is emptied and overrun is cleared. If an overrun event occurs in the same cycle, overrun=1 wins. A push in the same cycle as `clr_i` is discarded.
- Reset mid-frame: everything returns to reset values immediately (async). The link restarts from the left slot once reset is released with `en_i`=1.

## Timing
- First sclk rise: div_i+1 cycles after `en_i` is first seen high.
- One sclk period = 2*(div_i+1) clk cycles. One frame = 2*DATA_WIDTH*2*(div_i+1) clk cycles.
- Push → `data_valid_o`/data visible on the next cycle (registered FIFO, first-word fall-through).
- Pop: the head advances on the cycle after `valid && ready`; `fifo_cnt_o` updates in that same cycle.
- `overrun_o` asserts the cycle after the dropped push.

## Structure
- Package `i2s_adc_rx_pkg` holds:
  - `DIV_W`=8;
  - the typedef `i2s_pair_t` as a packed struct {left, right} of DATA_WIDTH each;
  - the enum `i2s_ch_e` {CH_LEFT=0, CH_RIGHT=1}.
- One sub-module: `i2s_adc_rx_fifo`, a synchronous FWFT FIFO of `i2s_pair_t` with flush, full, empty and count outputs.
- Clock generation and deserialisation stay in the top module.

## Test plan
- Reset, then `en_i`=1 with div_i=1: the first sclk rise occurs 2 cycles later; sclk period is 4 clk; lrck toggles every 64 clk; valid=0 throughout the first frame.
- Bench transmitter sends left=16'hA5C3, right=16'h3C5A repeatedly: the first pair popped is exactly {A5C3, 3C5A}; the partial first slot is never output.
- `data_ready_i`=0 for 10 frames (FIFO_DEPTH=8): cnt saturates at 8 and `overrun_o`=1; after draining, the 8 stored pairs are in order; `clr_i` then gives overrun=0 and cnt=0.
- Full FIFO with ready=1 held through a push cycle: cnt stays 8 and overrun stays 0.
- `en_i` dropped mid right slot: sclk/lrck go to 0 the next cycle and no push occurs; after re-enable, the first valid pair comes from the new full frame.
- Async `rst_i` pulse mid-frame with data in the FIFO: all outputs return to reset values without waiting for a clock edge, and cnt=0.
